fifo_rd_sched: RTL and testbench
================================

Name: fifo_rd_sched

Overview:
Round-robin read-port scheduler for the async FIFO read domain. It shares the single FIFO read port (empty flag, pop strobe, head data) between NUM_REQ consumers. A grant lasts for one burst of up to MAX_BURST beats. Sits in rclk domain directly on top of the read-pointer/empty logic and drives its rinc.

Parameters:
NUM_REQ, 4, number of consumers (2..8)
DSIZE, 8, FIFO data width
MAX_BURST, 4, max beats per grant (1..16)
EMPTY_TMO, 8, consecutive empty cycles in BURST before grant is released (>=1)

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  reset, asynchronous, active-low
rempty  input  1  FIFO empty flag (registered, rclk domain)
rdata  input  DSIZE  FIFO head data, valid whenever rempty=0
rinc  output  1  pop strobe to FIFO read pointer
req  input  NUM_REQ  level request per consumer
rd_ready  input  NUM_REQ  per-consumer accept
gnt  output  NUM_REQ  one-hot registered grant, 0 when none
out_valid  output  1  head beat offered to granted consumer
out_data  output  DSIZE  = rdata
out_id  output  clog2(NUM_REQ)  index of granted consumer (0 when none)

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, out_id=0, beat_cnt=0, tmo_cnt=0, last_id=NUM_REQ-1 (consumer 0 wins first arbitration); out_valid=0, rinc=0.
- States: IDLE, BURST, GAP.
- IDLE: if |req && !rempty, pick the first requester with req=1 searching last_id+1, last_id+2, ... modulo NUM_REQ. Register gnt/out_id; beat_cnt=0, tmo_cnt=0; next=BURST. Otherwise stay. Request to grant = 1 cycle.
- BURST: out_valid = !rempty; out_data = rdata (combinational). pop = out_valid && rd_ready[out_id]; rinc = pop. At most 1 pop per cycle; rinc never asserted when rempty=1 or outside BURST.
- On pop: beat_cnt++. If beat_cnt==MAX_BURST-1 (last beat popped), release.
- Release conditions, evaluated in the same cycle, any one suffices: last beat popped; req[out_id]=0 in a cycle with no pop; tmo_cnt==EMPTY_TMO-1 while rempty=1.
- tmo_cnt increments each BURST cycle with rempty=1; clears on any cycle with rempty=0.
- Release: last_id<=out_id; gnt<=0; next=GAP.
- GAP: 1 turnaround cycle, out_valid=0, then IDLE. Re-arbitration happens in IDLE, so minimum grant-to-grant spacing = burst + 2 cycles.
- Requester dropping req in a pop cycle: the beat completes; release takes effect the next non-pop cycle.
- rd_ready of non-granted consumers is ignored. out_valid is never asserted with gnt=0.
- req changes outside IDLE do not affect the current grant (except own-req drop as above).
- Reset mid-burst: immediate return to reset values; no rinc glitch (rinc is gated by state).
- No widths overflow: beat_cnt is clog2(MAX_BURST)+1 bits, tmo_cnt is clog2(EMPTY_TMO)+1 bits.

Optional Feature:
FIFO_RD_SCHED_STATS_EN: when defined, adds output beat_cnt_o [NUM_REQ*16] containing per-consumer 16-bit saturating counters of popped beats. Each counter resets to 0, increments on pop for out_id, and holds at 16'hFFFF. When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with req=4'b1111, FIFO holding 3 words -> rinc=0 throughout reset; first grant gnt=4'b0001 one cycle after release.
- req=4'b0101, 16 words queued, all rd_ready=1, MAX_BURST=4 -> 4 pops to id0, GAP, 4 pops to id2, GAP, back to id0; exactly 4 rinc per grant.
- Granted id1 with rd_ready[1]=0 for 5 cycles -> out_valid=1, rinc=0, out_data stable; 4 pops after rd_ready rises.
- Grant id3, FIFO drains after 2 beats, EMPTY_TMO=8 -> release exactly 8 cycles after rempty rises; gnt=0 next cycle.
- Granted id0 drops req after 1 beat -> release on the first non-pop cycle; next requester id1 is granted after GAP+IDLE.
- With FIFO_RD_SCHED_STATS_EN and 70000 beats to id2 -> counter 2 reads 16'hFFFF, others 0.

Source files
------------

// File: rtl/fifo_rd_sched_if.sv
// Read-port bundle between the FIFO read domain, the scheduler and its consumers.
// The master modport is the scheduler side; the slave modport is the FIFO/consumer side.
interface fifo_rd_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DSIZE   = 8
) ();
  localparam int IDW = $clog2(NUM_REQ);

  logic               rempty;
  logic [DSIZE-1:0]   rdata;
  logic               rinc;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rd_ready;
  logic [NUM_REQ-1:0] gnt;
  logic               out_valid;
  logic [DSIZE-1:0]   out_data;
  logic [IDW-1:0]     out_id;

  modport master (
    input  rempty, rdata, req, rd_ready,
    output rinc, gnt, out_valid, out_data, out_id
  );

  modport slave (
    output rempty, rdata, req, rd_ready,
    input  rinc, gnt, out_valid, out_data, out_id
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// Round-robin burst scheduler sharing one async-FIFO read port among NUM_REQ consumers.
// Optional per-consumer popped-beat counters are enabled by defining FIFO_RD_SCHED_STATS_EN.
module fifo_rd_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int EMPTY_TMO = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  fifo_rd_sched_if.master       bus
`ifdef FIFO_RD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] beat_cnt_o
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam int TCW = $clog2(EMPTY_TMO) + 1;

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     out_id;
  logic [IDW-1:0]     last_id;
  logic [BCW-1:0]     beat_cnt;
  logic [TCW-1:0]     tmo_cnt;

  logic               pop;
  logic               last_beat;
  logic               own_drop;
  logic               tmo_hit;
  logic               release_now;
  logic               arb_found;
  logic [IDW-1:0]     arb_id;
  logic [DSIZE-1:0]   head_data;
  int                 idx;

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_id) + k) % NUM_REQ;
      if (!arb_found && bus.req[idx]) begin
        arb_found = 1'b1;
        arb_id    = IDW'(idx);
      end
    end
  end

  assign pop         = (state == BURST) && !bus.rempty && bus.rd_ready[out_id];
  assign last_beat   = pop && (beat_cnt == BCW'(MAX_BURST - 1));
  assign own_drop    = !pop && !bus.req[out_id];
  assign tmo_hit     = bus.rempty && (tmo_cnt == TCW'(EMPTY_TMO - 1));
  assign release_now = last_beat || own_drop || tmo_hit;

  assign head_data     = bus.rdata;
  assign bus.out_data  = head_data;
  assign bus.out_valid = (state == BURST) && !bus.rempty;
  assign bus.rinc      = pop;
  assign bus.gnt       = gnt;
  assign bus.out_id    = out_id;

  // Grant FSM; the GAP cycle gives the FIFO one turnaround before re-arbitration.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      out_id   <= '0;
      last_id  <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found && !bus.rempty) begin
            gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_id;
            out_id   <= arb_id;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
          tmo_cnt <= bus.rempty ? tmo_cnt + TCW'(1) : '0;
          if (release_now) begin
            last_id <= out_id;
            gnt     <= '0;
            out_id  <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_RD_SCHED_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  // Saturating popped-beat counters, one per consumer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (pop && (stat_cnt[out_id] != 16'hFFFF)) begin
      stat_cnt[out_id] <= stat_cnt[out_id] + 16'd1;
    end
  end

  always_comb begin
    beat_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_cnt_o[i*16 +: 16] = stat_cnt[i];
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_sched.sv
// Scoreboard bench for fifo_rd_sched: a transaction-level owner/burst model predicts
// every cycle's grant and every popped beat, and a separate monitor compares the DUT.
module tb_fifo_rd_sched;
  localparam int NUM_REQ   = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;
  localparam int EMPTY_TMO = 8;
  localparam int IDW       = $clog2(NUM_REQ);

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_sched_if #(.NUM_REQ(NUM_REQ), .DSIZE(DSIZE)) bus_if ();

`ifdef FIFO_RD_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] beat_cnt_o;
`endif

  fifo_rd_sched #(
    .NUM_REQ  (NUM_REQ),
    .DSIZE    (DSIZE),
    .MAX_BURST(MAX_BURST),
    .EMPTY_TMO(EMPTY_TMO)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
`ifdef FIFO_RD_SCHED_STATS_EN
    .beat_cnt_o(beat_cnt_o),
`endif
    .bus       (bus_if.master)
  );

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     id;
    logic               valid;
    logic               rinc;
    logic [DSIZE-1:0]   data;
  } cyc_t;

  typedef struct {
    int               id;
    logic [DSIZE-1:0] data;
  } beat_t;

  cyc_t             expCycQ[$];
  beat_t            expBeatQ[$];
  logic [DSIZE-1:0] fifoQ[$];

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, how far into the burst, how long starved.
  int owner      = -1;
  int lastWinner = NUM_REQ - 1;
  int beatsDone  = 0;
  int emptyRun   = 0;
  bit inGap      = 1'b0;
  int statCnt [NUM_REQ];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic [NUM_REQ-1:0] reqV,
                               input logic [NUM_REQ-1:0] rdyV, input int nPush);
    cyc_t  c;
    beat_t b;
    bit    empty;
    bit    done;
    int    idx;
    @(negedge rclk);
    rrst_n = rstN;
    for (int i = 0; i < nPush; i++) fifoQ.push_back(DSIZE'($urandom));
    empty              = (fifoQ.size() == 0);
    bus_if.req         = reqV;
    bus_if.rd_ready    = rdyV;
    bus_if.rempty      = empty;
    bus_if.rdata       = empty ? DSIZE'($urandom) : fifoQ[0];
    c.gnt = '0; c.id = '0; c.valid = 1'b0; c.rinc = 1'b0; c.data = '0;
    if (!rstN) begin
      owner = -1; lastWinner = NUM_REQ - 1; inGap = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) statCnt[i] = 0;
      expCycQ.push_back(c);
      return;
    end
    if (owner >= 0) begin
      c.gnt   = NUM_REQ'(1) << owner;
      c.id    = IDW'(owner);
      c.valid = !empty;
      c.rinc  = !empty && rdyV[owner];
      c.data  = empty ? '0 : fifoQ[0];
    end
    expCycQ.push_back(c);
    if (c.rinc) begin
      b.id   = owner;
      b.data = fifoQ[0];
      expBeatQ.push_back(b);
      void'(fifoQ.pop_front());
      if (statCnt[owner] < 65535) statCnt[owner]++;
    end
    if (inGap) begin
      inGap = 1'b0;
    end else if (owner < 0) begin
      if (reqV != '0 && !empty) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (lastWinner + k) % NUM_REQ;
          if (reqV[idx]) begin
            owner = idx;
            break;
          end
        end
        beatsDone = 0;
        emptyRun  = 0;
      end
    end else begin
      done = 1'b0;
      if (c.rinc) begin
        beatsDone++;
        if (beatsDone == MAX_BURST) done = 1'b1;
      end else if (!reqV[owner]) begin
        done = 1'b1;
      end
      if (empty) begin
        if (emptyRun == EMPTY_TMO - 1) done = 1'b1;
        emptyRun++;
      end else begin
        emptyRun = 0;
      end
      if (done) begin
        lastWinner = owner;
        owner      = -1;
        inGap      = 1'b1;
      end
    end
  endtask

  cyc_t  mc;
  beat_t mb;

  // Monitor: compares each predicted cycle and each beat the DUT actually pops.
  initial begin
    forever begin
      @(negedge rclk);
      #2;
      if (expCycQ.size() > 0) begin
        mc = expCycQ.pop_front();
        checkOutput("gnt", 32'(bus_if.gnt), 32'(mc.gnt));
        checkOutput("out_id", 32'(bus_if.out_id), 32'(mc.id));
        checkOutput("out_valid", 32'(bus_if.out_valid), 32'(mc.valid));
        checkOutput("rinc", 32'(bus_if.rinc), 32'(mc.rinc));
        if (mc.valid) checkOutput("out_data", 32'(bus_if.out_data), 32'(mc.data));
      end
      if (bus_if.rinc === 1'b1) begin
        checkOutput("pop_expected", 32'(expBeatQ.size() > 0), 32'd1);
        if (expBeatQ.size() > 0) begin
          mb = expBeatQ.pop_front();
          checkOutput("beat_id", 32'(bus_if.out_id), 32'(mb.id));
          checkOutput("beat_data", 32'(bus_if.out_data), 32'(mb.data));
        end
      end
    end
  end

  logic [NUM_REQ-1:0] rndReq;

  initial begin
    bus_if.req      = '0;
    bus_if.rd_ready = '0;
    bus_if.rempty   = 1'b1;
    bus_if.rdata    = '0;
    for (int i = 0; i < NUM_REQ; i++) statCnt[i] = 0;

    // Reset held with all requesting and three words waiting.
    applyStimulus(1'b0, 4'b1111, 4'b1111, 3);
    repeat (3) applyStimulus(1'b0, 4'b1111, 4'b1111, 0);
    repeat (20) applyStimulus(1'b1, 4'b1111, 4'b1111, 0);

    // Two requesters alternating full bursts.
    applyStimulus(1'b1, 4'b0101, 4'b1111, 16);
    repeat (40) applyStimulus(1'b1, 4'b0101, 4'b1111, 0);

    // Granted consumer stalls before accepting.
    applyStimulus(1'b1, 4'b0010, 4'b0000, 8);
    repeat (5) applyStimulus(1'b1, 4'b0010, 4'b0000, 0);
    repeat (20) applyStimulus(1'b1, 4'b0010, 4'b1111, 0);

    // FIFO runs dry mid-burst, grant released on starvation timeout.
    applyStimulus(1'b1, 4'b1000, 4'b1111, 2);
    repeat (20) applyStimulus(1'b1, 4'b1000, 4'b1111, 0);

    // Owner withdraws after one beat; the other requester follows.
    applyStimulus(1'b1, 4'b0011, 4'b1111, 10);
    applyStimulus(1'b1, 4'b0011, 4'b1111, 0);
    repeat (20) applyStimulus(1'b1, 4'b0010, 4'b1110, 0);

    // Randomized traffic with occasional mid-run resets.
    rndReq = NUM_REQ'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rndReq = NUM_REQ'($urandom);
      applyStimulus(($urandom_range(0, 399) != 0), rndReq,
                    NUM_REQ'($urandom) | NUM_REQ'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    #5;
    checkOutput("leftover_beats", 32'(expBeatQ.size()), 32'd0);
`ifdef FIFO_RD_SCHED_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checkOutput($sformatf("stat_cnt%0d", i), 32'(beat_cnt_o[i*16 +: 16]), 32'(statCnt[i]));
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
